load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_align.sv | 54 +++++
 rtl/load_store_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: RV32I width codes,
// FSM state type and the request-legality check.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

   // True when the request must complete with an error and no memory access.
   function automatic logic req_error(input logic we, input logic [2:0] f3, input logic [1:0] off);
      logic legal;
      logic misaligned;
      if (we)
         legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      else
         legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
      misaligned = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
      return !legal || misaligned;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data, and merges
// store data into a previously read word (little-endian).
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] mem_word,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [31:0] shifted;
   assign shifted = mem_word >> {byte_off, 3'b000};

   always_comb begin
      load_data = '0;
      case (funct3)
         F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_W:    load_data = shifted;
         F3_BU:   load_data = {24'h0, shifted[7:0]};
         F3_HU:   load_data = {16'h0, shifted[15:0]};
         default: load_data = '0;
      endcase
   end

   // Each byte lane either keeps the read byte or takes the right-aligned store byte.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic       lane_hit;
         logic [7:0] src_byte;
         always_comb begin
            lane_hit = 1'b0;
            src_byte = store_data[8*gi +: 8];
            case (funct3)
               F3_B: begin
                  lane_hit = (byte_off == 2'(gi));
                  src_byte = store_data[7:0];
               end
               F3_H: begin
                  lane_hit = (byte_off[1] == 1'(gi / 2));
                  src_byte = store_data[8*(gi % 2) +: 8];
               end
               F3_W:    lane_hit = 1'b1;
               default: lane_hit = 1'b0;
            endcase
         end
         assign merged_word[8*gi +: 8] = lane_hit ? src_byte : mem_word[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time against a single-port word
// memory, with read-modify-write for sub-word stores.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int REGISTER_COUNT = 32,
   parameter int DATA_LENGTH    = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic                              req_we,
   input  logic [2:0]                        req_funct3,
   input  logic [31:0]                       req_addr,
   input  logic [31:0]                       req_wdata,
   output logic                              resp_valid,
   output logic [31:0]                       resp_rdata,
   output logic                              resp_err,
   output logic [$clog2(REGISTER_COUNT)-1:0] rw_addr_mem,
   output logic [DATA_LENGTH-1:0]            w_data_mem,
   output logic                              r_ctrl_mem,
   output logic                              w_ctrl_mem,
   input  logic [DATA_LENGTH-1:0]            r_data_mem
);

   localparam int IW = $clog2(REGISTER_COUNT);

   lsu_state_t       state_reg;
   logic             we_reg;
   logic [2:0]       funct3_reg;
   logic [IW+1:0]    addr_reg;
   logic [31:0]      wdata_reg;
   logic [31:0]      cap_reg;
   logic             req_ready_reg;
   logic             resp_valid_reg;
   logic             resp_err_reg;
   logic             r_ctrl_reg;
   logic             w_ctrl_reg;
   logic [31:0]      load_data;
   logic [31:0]      merged_word;
   logic             unused_addr_bits;

   // Upper address bits wrap modulo the memory size.
   assign unused_addr_bits = ^req_addr[31:IW+2];

   lsu_align u_align (
      .funct3      (funct3_reg),
      .byte_off    (addr_reg[1:0]),
      .mem_word    (cap_reg),
      .store_data  (wdata_reg),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= IDLE;
         we_reg         <= 1'b0;
         funct3_reg     <= '0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         cap_reg        <= '0;
         req_ready_reg  <= 1'b1;
         resp_valid_reg <= 1'b0;
         resp_err_reg   <= 1'b0;
         r_ctrl_reg     <= 1'b0;
         w_ctrl_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  we_reg        <= req_we;
                  funct3_reg    <= req_funct3;
                  addr_reg      <= req_addr[IW+1:0];
                  wdata_reg     <= req_wdata;
                  cap_reg       <= '0;
                  req_ready_reg <= 1'b0;
                  if (req_error(req_we, req_funct3, req_addr[1:0])) begin
                     state_reg      <= RESP;
                     resp_valid_reg <= 1'b1;
                     resp_err_reg   <= 1'b1;
                  end else if (req_we && (req_funct3 == F3_W)) begin
                     state_reg  <= WRITE;
                     w_ctrl_reg <= 1'b1;
                  end else begin
                     state_reg  <= READ;
                     r_ctrl_reg <= 1'b1;
                  end
               end
            end
            READ: begin
               cap_reg    <= r_data_mem[31:0];
               r_ctrl_reg <= 1'b0;
               if (we_reg) begin
                  state_reg  <= WRITE;
                  w_ctrl_reg <= 1'b1;
               end else begin
                  state_reg      <= RESP;
                  resp_valid_reg <= 1'b1;
               end
            end
            WRITE: begin
               w_ctrl_reg     <= 1'b0;
               state_reg      <= RESP;
               resp_valid_reg <= 1'b1;
            end
            RESP: begin
               resp_valid_reg <= 1'b0;
               resp_err_reg   <= 1'b0;
               req_ready_reg  <= 1'b1;
               state_reg      <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign req_ready   = req_ready_reg;
   assign resp_valid  = resp_valid_reg;
   assign resp_err    = resp_err_reg;
   assign resp_rdata  = (resp_valid_reg && !we_reg && !resp_err_reg) ? load_data : '0;
   assign r_ctrl_mem  = r_ctrl_reg;
   assign w_ctrl_mem  = w_ctrl_reg;
   assign rw_addr_mem = (r_ctrl_reg || w_ctrl_reg) ? addr_reg[IW+1:2] : '0;
   // Word stores bypass the capture register: the merge passes store data through.
   assign w_data_mem  = w_ctrl_reg ? merged_word : '0;

endmodule
